// File: rtl/sr_ff_bank.sv
// Bank of WIDTH clocked SR flip-flops with a parameter-selected S=R=1 resolution,
// per-channel invalid flags, a change pulse and a saturating invalid-event counter.
module sr_ff_bank #(
    parameter int                 WIDTH     = 4,
    parameter int                 MODE      = 0,
    parameter int                 CNT_W     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             clr_cnt,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic [WIDTH-1:0] invalid,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic             changed
);

    if (MODE < 0 || MODE > 3) begin : g_mode_err
        $fatal(1, "sr_ff_bank: MODE must be 0..3");
    end

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] inv_q, inv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chg_q, chg_d;

    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] res_11;

    assign both = s & r;

    // Value a channel takes when both set and reset are requested.
    always_comb begin
        res_11 = q_q;
        case (MODE)
            1:       res_11 = {WIDTH{1'b1}};
            2:       res_11 = {WIDTH{1'b0}};
            3:       res_11 = ~q_q;
            default: res_11 = q_q;
        endcase
    end

    always_comb begin
        q_d   = q_q;
        inv_d = '0;
        cnt_d = cnt_q;
        if (en) begin
            q_d   = (q_q & ~(s | r)) | (s & ~r) | (both & res_11);
            inv_d = both;
        end
        chg_d = |(q_d ^ q_q);
        // Clear takes priority over any increment on the same edge.
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (en && (|both) && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q   <= RESET_VAL;
            inv_q <= '0;
            cnt_q <= '0;
            chg_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            inv_q <= inv_d;
            cnt_q <= cnt_d;
            chg_q <= chg_d;
        end
    end

    // q_bar is derived from the single q register so the two can never disagree.
    assign q           = q_q;
    assign q_bar       = ~q_q;
    assign invalid     = inv_q;
    assign invalid_cnt = cnt_q;
    assign changed     = chg_q;

endmodule
